// File: rtl/lab1_idiv_int_div_iter.sv
// Iterative 32/32 restoring divider: one quotient bit per cycle, fixed 34-cycle latency.
// Define LAB1_IDIV_SIGNED_EN for two's-complement operands (truncating quotient, remainder takes dividend sign).
module lab1_idiv_int_div_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_val,
    output logic        req_rdy,
    input  logic [63:0] req_msg,
    output logic        resp_val,
    input  logic        resp_rdy,
    output logic [63:0] resp_msg
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [5:0]          cnt;
    logic [2*DATA_W-1:0] acc;
    logic [DATA_W-1:0]   divisor_r;
    logic                req_go;
    logic [2*DATA_W:0]   shifted;
    logic signed [DATA_W+1:0] trial;
    logic [2*DATA_W-1:0] step;
    logic [2*DATA_W-1:0] result;

`ifdef LAB1_IDIV_SIGNED_EN
    logic dvd_neg, dvs_neg;

    function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v);
        return (v < 0) ? DATA_W'(-v) : DATA_W'(v);
    endfunction

    function automatic logic [2*DATA_W-1:0] sign_fix(input logic [2*DATA_W-1:0] raw,
                                                     input logic neg_a, input logic neg_b,
                                                     input logic b_zero);
        logic signed [DATA_W-1:0] q, r;
        q = raw[DATA_W-1:0];
        r = raw[2*DATA_W-1:DATA_W];
        // divide-by-zero keeps the all-ones quotient regardless of dividend sign
        if ((neg_a ^ neg_b) && !b_zero) q = -q;
        if (neg_a) r = -r;
        return {r, q};
    endfunction

    assign result = sign_fix(acc, dvd_neg, dvs_neg, divisor_r == '0);
`else
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
        return v;
    endfunction

    assign result = acc;
`endif

    assign req_go = req_val && req_rdy;

    // Restoring step on {remainder, quotient}; bit 64 of shifted is the carry out of the remainder
    assign shifted = {acc, 1'b0};
    assign trial   = $signed({1'b0, shifted[2*DATA_W:DATA_W]}) - $signed({2'b00, divisor_r});
    assign step    = (trial < 0) ? shifted[2*DATA_W-1:0]
                                 : {trial[DATA_W-1:0], shifted[DATA_W-1:1], 1'b1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_rdy   = 1'b0;
        resp_val  = 1'b0;
        resp_msg  = '0;
        case (state)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_val) state_nxt = CALC;
            end
            CALC: begin
                if (cnt == 6'd1) state_nxt = DONE;
            end
            DONE: begin
                resp_val = 1'b1;
                resp_msg = result;
                if (resp_rdy) state_nxt = IDLE;
            end
            default: begin
                req_rdy   = 1'bx;
                resp_val  = 1'bx;
                resp_msg  = 'x;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            acc       <= '0;
            divisor_r <= '0;
`ifdef LAB1_IDIV_SIGNED_EN
            dvd_neg   <= 1'b0;
            dvs_neg   <= 1'b0;
`endif
        end else if (req_go) begin
            cnt       <= 6'd32;
            acc       <= {{DATA_W{1'b0}}, mag(req_msg[2*DATA_W-1:DATA_W])};
            divisor_r <= mag(req_msg[DATA_W-1:0]);
`ifdef LAB1_IDIV_SIGNED_EN
            dvd_neg   <= req_msg[2*DATA_W-1];
            dvs_neg   <= req_msg[DATA_W-1];
`endif
        end else if (state == CALC) begin
            acc <= step;
            cnt <= cnt - 6'd1;
        end
    end

endmodule

// File: tb/tb_lab1_idiv_int_div_iter.sv
// Directed bench for lab1_idiv_int_div_iter: latency, handshake, backpressure, reset abort, boundary operands.
module tb_lab1_idiv_int_div_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_val;
    logic        req_rdy;
    logic [63:0] req_msg;
    logic        resp_val;
    logic        resp_rdy;
    logic [63:0] resp_msg;

    int n_chk = 0;
    int n_err = 0;

    lab1_idiv_int_div_iter dut (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_msg  (req_msg),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        chk("req_rdy_idle", 64'(req_rdy), 64'd1);
        req_msg = {a, b};
        req_val = 1'b1;
        @(posedge clk); #1;
        req_val = 1'b0;
    endtask

    // lat is the cycle index (accepting cycle = 0) in which resp_val is first seen
    task automatic wait_resp(input int start, output int lat);
        lat = start;
        while (resp_val !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r);
        int lat;
        send(a, b);
        wait_resp(1, lat);
        chk({tag, "_lat"}, 64'(lat), 64'd33);
        chk({tag, "_msg"}, resp_msg, {r, q});
        resp_rdy = 1'b1;
        @(posedge clk); #1;
        resp_rdy = 1'b0;
        chk({tag, "_idle"}, 64'(req_rdy), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  lat;
        bit  seen;
        reset    = 1'b1;
        req_val  = 1'b0;
        resp_rdy = 1'b0;
        req_msg  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_rdy",  64'(req_rdy),  64'd1);
        chk("rst_resp_val", 64'(resp_val), 64'd0);
        chk("rst_resp_msg", resp_msg,      64'd0);
        reset = 1'b0;

        // 100/7 with resp_rdy held high and spurious requests during CALC
        resp_rdy = 1'b1;
        send(32'd100, 32'd7);
        chk("calc_req_rdy",  64'(req_rdy),  64'd0);
        chk("calc_resp_val", 64'(resp_val), 64'd0);
        for (int i = 0; i < 5; i++) begin
            req_val = 1'b1;
            req_msg = {32'd50, 32'd5};
            @(posedge clk); #1;
        end
        req_val = 1'b0;
        wait_resp(6, lat);
        chk("d100_7_lat", 64'(lat), 64'd33);
        chk("d100_7_msg", resp_msg, {32'd2, 32'd14});
        chk("done_req_rdy", 64'(req_rdy), 64'd0);
        req_val = 1'b1;
        req_msg = {32'd9, 32'd3};
        @(posedge clk); #1;
        chk("no_turnaround", 64'(req_rdy), 64'd1);
        chk("idle_resp_val", 64'(resp_val), 64'd0);
        req_val  = 1'b0;
        resp_rdy = 1'b0;

        run("divzero", 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678);

        // backpressure: 1000/7 = 142 r 6
        send(32'd1000, 32'd7);
        wait_resp(1, lat);
        chk("bp_lat", 64'(lat), 64'd33);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_resp_val", 64'(resp_val), 64'd1);
            chk("bp_resp_msg", resp_msg, {32'd6, 32'd142});
            chk("bp_req_rdy",  64'(req_rdy),  64'd0);
        end
        resp_rdy = 1'b1;
        @(posedge clk); #1;
        resp_rdy = 1'b0;
        chk("bp_release_rdy", 64'(req_rdy),  64'd1);
        chk("bp_release_val", 64'(resp_val), 64'd0);

        // reset during CALC cycle 15
        send(32'd12345, 32'd67);
        repeat (14) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        chk("abort_req_rdy",  64'(req_rdy),  64'd1);
        chk("abort_resp_val", 64'(resp_val), 64'd0);
        chk("abort_resp_msg", resp_msg,      64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen  = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (resp_val !== 1'b0) seen = 1'b1;
        end
        chk("abort_no_resp", 64'(seen), 64'd0);
        run("d9_3", 32'd9, 32'd3, 32'd3, 32'd0);

`ifdef LAB1_IDIV_SIGNED_EN
        run("s_m7_2",    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF);
        run("s_min_m1",  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
        run("s_neg_div0", 32'hFFFFFFF9, 32'd0,       32'hFFFFFFFF, 32'hFFFFFFF9);
`else
        run("u_max_1",   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0);
        run("u_5_max",   32'd5,        32'hFFFFFFFF, 32'd0,        32'd5);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
